// File: rtl/ycc_pkg.sv
// Shared constants, opcode encoding and helpers for the YCbCr-to-RGB custom instruction.
// Coefficients are unsigned magnitudes in Q.16 fixed point.
package ycc_pkg;

  localparam int FRAC_W_DEF = 16;

  localparam logic signed [31:0] KR  = 32'sd91881;
  localparam logic signed [31:0] KGB = 32'sd22554;
  localparam logic signed [31:0] KGR = 32'sd46802;
  localparam logic signed [31:0] KB  = 32'sd116130;

  typedef enum logic [2:0] {
    OP_R       = 3'd0,
    OP_G       = 3'd1,
    OP_B       = 3'd2,
    OP_RGB     = 3'd3,
    OP_CNT     = 3'd4,
    OP_CNT_CLR = 3'd5
  } ycc_op_e;

  function automatic int chroma_offset(input int pix_w);
    return 32'sd1 <<< (pix_w - 1);
  endfunction

endpackage

// File: rtl/ycc_round_clamp.sv
// Saturates a signed channel sum into the unsigned pixel range.
// Also reports whether saturation happened.
module ycc_round_clamp #(
  parameter int PIX_W = 8
) (
  input  logic signed [31:0]      sum,
  output logic        [PIX_W-1:0] pix,
  output logic                    clamped
);

  localparam logic signed [31:0] PIX_MAX = (32'sd1 <<< PIX_W) - 32'sd1;

  // Select the in-range value, or the nearest bound on overflow.
  always_comb begin
    pix     = {PIX_W{1'b0}};
    clamped = 1'b0;
    if (sum < 32'sd0) begin
      pix     = {PIX_W{1'b0}};
      clamped = 1'b1;
    end else if (sum > PIX_MAX) begin
      pix     = {PIX_W{1'b1}};
      clamped = 1'b1;
    end else begin
      pix     = sum[PIX_W-1:0];
      clamped = 1'b0;
    end
  end

endmodule

// File: rtl/ycc_rgb_convert_ci.sv
// Three-stage Nios II custom instruction: YCbCr sample to R, G, B or packed RGB.
// Also keeps a saturating count of conversions that clamped.
module ycc_rgb_convert_ci
  import ycc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PIX_W  = 8,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [2:0]        n,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int                 OFF_I = chroma_offset(PIX_W);
  localparam logic [PIX_W:0]     OFF   = OFF_I[PIX_W:0];
  localparam logic signed [31:0] HALF  = 32'sd1 <<< (FRAC_W - 1);

  logic                    unused_s;
  logic signed [PIX_W:0]   cb_s, cr_s;
  logic [PIX_W-1:0]        y1_r;
  logic signed [PIX_W:0]   cb1_r, cr1_r;
  logic [2:0]              n1_r;
  logic                    v1_r;
  logic signed [31:0]      cb_ext_s, cr_ext_s;
  logic signed [31:0]      pr_r, pgb_r, pgr_r, pb_r;
  logic [PIX_W-1:0]        y2_r;
  logic [2:0]              n2_r;
  logic                    v2_r;
  logic signed [31:0]      y_ext_s, sum_r_s, sum_g_s, sum_b_s;
  logic [PIX_W-1:0]        r_pix_s, g_pix_s, b_pix_s;
  logic                    r_clamp_s, g_clamp_s, b_clamp_s;
  logic                    hit_s;
  logic [DATA_W-1:0]       res_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic                    done_r;
  logic [DATA_W-1:0]       result_r;

  assign unused_s = ^{data_a[DATA_W-1:PIX_W], data_b[DATA_W-1:2*PIX_W]};

  // Mod-2^(PIX_W+1) subtraction yields the two's-complement centred chroma.
  assign cb_s = {1'b0, data_b[PIX_W-1:0]} - OFF;
  assign cr_s = {1'b0, data_b[2*PIX_W-1:PIX_W]} - OFF;

  // Stage 1: capture operands and opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      y1_r  <= {PIX_W{1'b0}};
      cb1_r <= {(PIX_W+1){1'b0}};
      cr1_r <= {(PIX_W+1){1'b0}};
      n1_r  <= 3'd0;
      v1_r  <= 1'b0;
    end else if (clk_en) begin
      y1_r  <= data_a[PIX_W-1:0];
      cb1_r <= cb_s;
      cr1_r <= cr_s;
      n1_r  <= n;
      v1_r  <= start;
    end
  end

  assign cb_ext_s = 32'(cb1_r);
  assign cr_ext_s = 32'(cr1_r);

  // Stage 2: register the four coefficient products.
  always_ff @(posedge clk) begin
    if (reset) begin
      pr_r  <= 32'sd0;
      pgb_r <= 32'sd0;
      pgr_r <= 32'sd0;
      pb_r  <= 32'sd0;
      y2_r  <= {PIX_W{1'b0}};
      n2_r  <= 3'd0;
      v2_r  <= 1'b0;
    end else if (clk_en) begin
      pr_r  <= KR  * cr_ext_s;
      pgb_r <= KGB * cb_ext_s;
      pgr_r <= KGR * cr_ext_s;
      pb_r  <= KB  * cb_ext_s;
      y2_r  <= y1_r;
      n2_r  <= n1_r;
      v2_r  <= v1_r;
    end
  end

  // Green sums both products before rounding so only one rounding error is taken.
  assign y_ext_s = 32'(y2_r);
  assign sum_r_s = y_ext_s + ((pr_r + HALF) >>> FRAC_W);
  assign sum_g_s = y_ext_s - ((pgb_r + pgr_r + HALF) >>> FRAC_W);
  assign sum_b_s = y_ext_s + ((pb_r + HALF) >>> FRAC_W);

  ycc_round_clamp #(.PIX_W(PIX_W)) u_clamp_r (.sum(sum_r_s), .pix(r_pix_s), .clamped(r_clamp_s));
  ycc_round_clamp #(.PIX_W(PIX_W)) u_clamp_g (.sum(sum_g_s), .pix(g_pix_s), .clamped(g_clamp_s));
  ycc_round_clamp #(.PIX_W(PIX_W)) u_clamp_b (.sum(sum_b_s), .pix(b_pix_s), .clamped(b_clamp_s));

  // Stage 3 result mux and clamp-hit selection by opcode.
  always_comb begin
    res_s = {DATA_W{1'b0}};
    hit_s = 1'b0;
    case (n2_r)
      OP_R: begin
        res_s = {{(DATA_W-PIX_W){1'b0}}, r_pix_s};
        hit_s = r_clamp_s;
      end
      OP_G: begin
        res_s = {{(DATA_W-PIX_W){1'b0}}, g_pix_s};
        hit_s = g_clamp_s;
      end
      OP_B: begin
        res_s = {{(DATA_W-PIX_W){1'b0}}, b_pix_s};
        hit_s = b_clamp_s;
      end
      OP_RGB: begin
        res_s = {{(DATA_W-3*PIX_W){1'b0}}, r_pix_s, g_pix_s, b_pix_s};
        hit_s = r_clamp_s | g_clamp_s | b_clamp_s;
      end
      OP_CNT, OP_CNT_CLR: begin
        res_s = {{(DATA_W-CNT_W){1'b0}}, cnt_r};
        hit_s = 1'b0;
      end
      default: begin
        res_s = {DATA_W{1'b0}};
        hit_s = 1'b0;
      end
    endcase
  end

  // Counter next value: clear on read-and-clear, else saturating increment.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (v2_r && (n2_r == OP_CNT_CLR)) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (v2_r && hit_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Stage 3: register result, done pulse and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r   <= 1'b0;
      result_r <= {DATA_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (clk_en) begin
      done_r <= v2_r;
      cnt_r  <= cnt_nxt_s;
      if (v2_r) begin
        result_r <= res_s;
      end
    end
  end

  assign done   = done_r;
  assign result = result_r;

endmodule
